// File: rtl/rv32ima_pkg.sv
// Shared types for the memory responder: load/store access widths, responder FSM states
// and the lane-offset helpers used when an access is granted.
package rv32ima_pkg;

    localparam int LDST_WIDTH_W = 2;

    typedef enum logic [LDST_WIDTH_W-1:0] {
        LDST_B = 2'd0,
        LDST_H = 2'd1,
        LDST_W = 2'd2
    } ldst_width_t;

    typedef enum logic [1:0] {
        IDLE,
        IACC,
        DACC,
        RESP
    } mem_resp_state_t;

    // Byte lane of the access with the low bits the size cannot use forced to zero.
    function automatic logic [1:0] lane_offset(input logic [LDST_WIDTH_W-1:0] width,
                                               input logic [1:0]              a);
        case (width)
            LDST_B:  return a;
            LDST_H:  return {a[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [LDST_WIDTH_W-1:0] width,
                                           input logic [1:0]              a);
        case (width)
            LDST_B:  return 1'b0;
            LDST_H:  return a[0];
            default: return |a;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for B/H/W accesses: write enables and replicated write data for
// stores, zero-extended LSB-aligned extraction for loads.
module mem_lane_align
    import rv32ima_pkg::*;
(
    input  logic [LDST_WIDTH_W-1:0] width,
    input  logic [1:0]              offset,
    input  logic [31:0]             dstore,
    input  logic [31:0]             rdata,
    output logic [3:0]              be,
    output logic [31:0]             wdata,
    output logic [31:0]             load
);

    logic [31:0] rshift;

    always_comb begin
        rshift = rdata >> {offset, 3'b000};
        case (width)
            LDST_B: begin
                be    = 4'b0001 << offset;
                wdata = {4{dstore[7:0]}};
                load  = {24'h0, rshift[7:0]};
            end
            LDST_H: begin
                be    = 4'b0011 << offset;
                wdata = {2{dstore[15:0]}};
                load  = {16'h0, rshift[15:0]};
            end
            default: begin
                be    = 4'hF;
                wdata = dstore;
                load  = rdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// Arbitrates instruction fetches and data loads/stores onto one single-port RAM.
// Optional build macro MEM_MISALIGN_TRAP_EN: misaligned data accesses bypass the RAM and raise dmisalign.
module mem_responder
    import rv32ima_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int RAM_AW       = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             iaddr,
    input  logic                    iren,
    output logic [31:0]             idata,
    output logic                    ihit,
    input  logic [31:0]             daddr,
    input  logic                    dren,
    input  logic                    dwen,
    input  logic [31:0]             dstore,
    input  logic [LDST_WIDTH_W-1:0] dwidth,
    output logic [31:0]             dload,
    output logic                    dhit,
    output logic [RAM_AW-1:0]       ram_addr,
    output logic                    ram_ren,
    output logic                    ram_wen,
    output logic [3:0]              ram_be,
    output logic [31:0]             ram_wdata,
    input  logic [31:0]             ram_rdata,
    input  logic                    ram_ready
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic                    dmisalign
`endif
);

    localparam int                  STARVE_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    mem_resp_state_t           state_q, state_d;
    logic [STARVE_W-1:0]       starve_q, starve_d;
    logic                      is_store_q, is_store_d;
    logic [LDST_WIDTH_W-1:0]   width_q, width_d;
    logic [1:0]                offset_q, offset_d;
    logic [RAM_AW-1:0]         ram_addr_q, ram_addr_d;
    logic                      ram_ren_q, ram_ren_d;
    logic                      ram_wen_q, ram_wen_d;
    logic [3:0]                ram_be_q, ram_be_d;
    logic [31:0]               ram_wdata_q, ram_wdata_d;
    logic [31:0]               idata_q, idata_d;
    logic [31:0]               dload_q, dload_d;
    logic                      ihit_q, ihit_d;
    logic                      dhit_q, dhit_d;
`ifdef MEM_MISALIGN_TRAP_EN
    logic                      misalign_q, misalign_d;
    logic                      dmisalign_q, dmisalign_d;
`endif

    logic [LDST_WIDTH_W-1:0]   al_width;
    logic [1:0]                al_offset;
    logic [31:0]               al_dstore;
    logic [3:0]                al_be;
    logic [31:0]               al_wdata;
    logic [31:0]               al_load;
    logic                      unused_addr_bits;

    assign unused_addr_bits = ^{iaddr[31:RAM_AW+2], iaddr[1:0], daddr[31:RAM_AW+2]};

    // The aligner sees the live request while granting and the latched access afterwards.
    always_comb begin
        if (state_q == IDLE) begin
            al_width  = dwidth;
            al_offset = lane_offset(dwidth, daddr[1:0]);
            al_dstore = dstore;
        end else begin
            al_width  = width_q;
            al_offset = offset_q;
            al_dstore = 32'h0;
        end
    end

    mem_lane_align u_align (
        .width  (al_width),
        .offset (al_offset),
        .dstore (al_dstore),
        .rdata  (ram_rdata),
        .be     (al_be),
        .wdata  (al_wdata),
        .load   (al_load)
    );

    always_comb begin
        // NOTE: every _d starts from its _q (or a pulse default) so no path infers a latch.
        state_d     = state_q;
        starve_d    = starve_q;
        is_store_d  = is_store_q;
        width_d     = width_q;
        offset_d    = offset_q;
        ram_addr_d  = ram_addr_q;
        ram_ren_d   = ram_ren_q;
        ram_wen_d   = ram_wen_q;
        ram_be_d    = ram_be_q;
        ram_wdata_d = ram_wdata_q;
        idata_d     = idata_q;
        dload_d     = dload_q;
        ihit_d      = 1'b0;
        dhit_d      = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        misalign_d  = misalign_q;
        dmisalign_d = 1'b0;
`endif
        if (!iren) starve_d = '0;

        unique case (state_q)
            IDLE: begin
                if ((dren || dwen) && (starve_q < STARVE_MAX || !iren)) begin
                    state_d     = DACC;
                    is_store_d  = dwen;
                    width_d     = dwidth;
                    offset_d    = al_offset;
                    ram_addr_d  = daddr[RAM_AW+1:2];
                    ram_be_d    = dwen ? al_be : 4'h0;
                    ram_wdata_d = dwen ? al_wdata : 32'h0;
                    ram_ren_d   = !dwen;
                    ram_wen_d   = dwen;
                    if (iren) starve_d = starve_q + 1'b1;
`ifdef MEM_MISALIGN_TRAP_EN
                    misalign_d = is_misaligned(dwidth, daddr[1:0]);
                    if (misalign_d) begin
                        ram_ren_d = 1'b0;
                        ram_wen_d = 1'b0;
                    end
`endif
                end else if (iren) begin
                    state_d     = IACC;
                    starve_d    = '0;
                    ram_addr_d  = iaddr[RAM_AW+1:2];
                    ram_be_d    = 4'h0;
                    ram_wdata_d = 32'h0;
                    ram_ren_d   = 1'b1;
                    ram_wen_d   = 1'b0;
                end
            end
            IACC: begin
                if (ram_ready) begin
                    state_d   = RESP;
                    ram_ren_d = 1'b0;
                    idata_d   = ram_rdata;
                    ihit_d    = 1'b1;
                end
            end
            DACC: begin
`ifdef MEM_MISALIGN_TRAP_EN
                if (misalign_q) begin
                    state_d     = RESP;
                    dhit_d      = 1'b1;
                    dmisalign_d = 1'b1;
                    dload_d     = 32'h0;
                end else
`endif
                if (ram_ready) begin
                    state_d   = RESP;
                    ram_ren_d = 1'b0;
                    ram_wen_d = 1'b0;
                    dhit_d    = 1'b1;
                    dload_d   = is_store_q ? 32'h0 : al_load;
                end
            end
            RESP: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            is_store_q  <= 1'b0;
            width_q     <= '0;
            offset_q    <= 2'b00;
            ram_addr_q  <= '0;
            ram_ren_q   <= 1'b0;
            ram_wen_q   <= 1'b0;
            ram_be_q    <= 4'h0;
            ram_wdata_q <= 32'h0;
            idata_q     <= 32'h0;
            dload_q     <= 32'h0;
            ihit_q      <= 1'b0;
            dhit_q      <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_q  <= 1'b0;
            dmisalign_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            is_store_q  <= is_store_d;
            width_q     <= width_d;
            offset_q    <= offset_d;
            ram_addr_q  <= ram_addr_d;
            ram_ren_q   <= ram_ren_d;
            ram_wen_q   <= ram_wen_d;
            ram_be_q    <= ram_be_d;
            ram_wdata_q <= ram_wdata_d;
            idata_q     <= idata_d;
            dload_q     <= dload_d;
            ihit_q      <= ihit_d;
            dhit_q      <= dhit_d;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_q  <= misalign_d;
            dmisalign_q <= dmisalign_d;
`endif
        end
    end

    assign idata     = idata_q;
    assign ihit      = ihit_q;
    assign dload     = dload_q;
    assign dhit      = dhit_q;
    assign ram_addr  = ram_addr_q;
    assign ram_ren   = ram_ren_q;
    assign ram_wen   = ram_wen_q;
    assign ram_be    = ram_be_q;
    assign ram_wdata = ram_wdata_q;
`ifdef MEM_MISALIGN_TRAP_EN
    assign dmisalign = dmisalign_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: byte-addressed memory model, wait-state RAM,
// directed corner cases followed by randomized fetch/load/store traffic.
module tb_mem_responder;
    import rv32ima_pkg::*;

    localparam int STARVE_LIMIT = 4;
    localparam int RAM_AW       = 16;
    localparam int MEM_WORDS    = 1024;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [31:0]             iaddr;
    logic                    iren;
    logic [31:0]             idata;
    logic                    ihit;
    logic [31:0]             daddr;
    logic                    dren;
    logic                    dwen;
    logic [31:0]             dstore;
    logic [LDST_WIDTH_W-1:0] dwidth;
    logic [31:0]             dload;
    logic                    dhit;
    logic [RAM_AW-1:0]       ram_addr;
    logic                    ram_ren;
    logic                    ram_wen;
    logic [3:0]              ram_be;
    logic [31:0]             ram_wdata;
    logic [31:0]             ram_rdata;
    logic                    ram_ready;
`ifdef MEM_MISALIGN_TRAP_EN
    logic                    dmisalign;
`endif

    always #5 clk = ~clk;

    mem_responder #(.STARVE_LIMIT(STARVE_LIMIT), .RAM_AW(RAM_AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .iaddr     (iaddr),
        .iren      (iren),
        .idata     (idata),
        .ihit      (ihit),
        .daddr     (daddr),
        .dren      (dren),
        .dwen      (dwen),
        .dstore    (dstore),
        .dwidth    (dwidth),
        .dload     (dload),
        .dhit      (dhit),
        .ram_addr  (ram_addr),
        .ram_ren   (ram_ren),
        .ram_wen   (ram_wen),
        .ram_be    (ram_be),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .ram_ready (ram_ready)
`ifdef MEM_MISALIGN_TRAP_EN
        ,
        .dmisalign (dmisalign)
`endif
    );

    // RAM behind the DUT plus an independent byte-addressed reference memory.
    logic [31:0] mem   [MEM_WORDS];
    logic [7:0]  model [MEM_WORDS*4];
    int          wait_left  = 0;
    int          writes     = 0;
    int          wen_cycles = 0;
    int          tests_run  = 0;
    int          failed     = 0;

    assign ram_rdata = mem[ram_addr[9:0]];

    always @(posedge clk) begin
        if (ram_wen) wen_cycles++;
        if (ram_wen && ram_ready) begin
            for (int k = 0; k < 4; k++)
                if (ram_be[k]) mem[ram_addr[9:0]][8*k +: 8] = ram_wdata[8*k +: 8];
            writes++;
        end
    end

    always @(negedge clk) begin
        if (ram_ren || ram_wen) begin
            if (wait_left > 0) begin
                ram_ready = 1'b0;
                wait_left--;
            end else begin
                ram_ready = 1'b1;
            end
        end else begin
            ram_ready = (wait_left == 0);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] eff_addr(input logic [31:0] a, input logic [1:0] w);
        case (w)
            2'd0:    return a;
            2'd1:    return {a[31:1], 1'b0};
            default: return {a[31:2], 2'b00};
        endcase
    endfunction

    function automatic int nbytes(input logic [1:0] w);
        case (w)
            2'd0:    return 1;
            2'd1:    return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] w);
        logic [31:0] ea = eff_addr(a, w);
        logic [31:0] v  = 32'h0;
        for (int i = 0; i < nbytes(w); i++) v = v | (32'(model[ea + i]) << (8 * i));
        return v;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [1:0] w, input logic [31:0] d);
        logic [31:0] ea = eff_addr(a, w);
        for (int i = 0; i < nbytes(w); i++) model[ea + i] = d[8*i +: 8];
    endtask

    task automatic set_word(input int idx, input logic [31:0] v);
        mem[idx] = v;
        for (int i = 0; i < 4; i++) model[idx*4 + i] = v[8*i +: 8];
    endtask

    // Results of the most recent transaction.
    logic              res_hit, res_other, res_mis, cap_valid, cap_ren, cap_wen, strobe_stable;
    logic [31:0]       res_data, cap_wdata;
    logic [3:0]        cap_be;
    logic [RAM_AW-1:0] cap_addr;
    int                res_edges, strobe_cycles;

    task automatic run_until_hit(input logic want_data);
        res_hit = 1'b0; res_other = 1'b0; res_mis = 1'b0; res_edges = 0;
        cap_valid = 1'b0; strobe_stable = 1'b1; strobe_cycles = 0;
        while (!res_hit && res_edges < 64) begin
            @(posedge clk); #1;
            res_edges++;
            if (ram_ren || ram_wen) begin
                strobe_cycles++;
                if (!cap_valid) begin
                    cap_valid = 1'b1; cap_addr = ram_addr; cap_ren = ram_ren;
                    cap_wen = ram_wen; cap_be = ram_be; cap_wdata = ram_wdata;
                end else if ({ram_addr, ram_ren, ram_wen, ram_be, ram_wdata} !==
                             {cap_addr, cap_ren, cap_wen, cap_be, cap_wdata}) begin
                    strobe_stable = 1'b0;
                end
            end
            if (want_data ? dhit : ihit) begin
                res_hit   = 1'b1;
                res_data  = want_data ? dload : idata;
                res_other = want_data ? ihit : dhit;
`ifdef MEM_MISALIGN_TRAP_EN
                res_mis   = dmisalign;
`endif
            end
        end
    endtask

    task automatic data_access(input logic rd, input logic wr, input logic [31:0] a,
                               input logic [1:0] w, input logic [31:0] sdata, input int waits);
        wait_left = waits;
        @(negedge clk);
        daddr = a; dwidth = w; dstore = sdata; dren = rd; dwen = wr;
        run_until_hit(1'b1);
        @(negedge clk);
        dren = 1'b0; dwen = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a, input int waits);
        wait_left = waits;
        @(negedge clk);
        iaddr = a; iren = 1'b1;
        run_until_hit(1'b0);
        @(negedge clk);
        iren = 1'b0;
    endtask

    initial begin
        int          n, edges, consec, wr_before;
        logic        hit_seen;
        logic [31:0] order [6];
        logic [31:0] a, sd, exp_v;
        logic [1:0]  w;
        int          kind, waits, bad_words;

        rst = 1'b1; iaddr = 32'h0; iren = 1'b0; daddr = 32'h0; dren = 1'b0; dwen = 1'b0;
        dstore = 32'h0; dwidth = 2'd0;
        for (int i = 0; i < MEM_WORDS; i++) set_word(i, $urandom);

        repeat (2) @(negedge clk);
        check("rst_ihit", {31'h0, ihit}, 32'h0);
        check("rst_dhit", {31'h0, dhit}, 32'h0);
        check("rst_strobes", {30'h0, ram_ren, ram_wen}, 32'h0);
        check("rst_be_wdata", ram_wdata | {28'h0, ram_be}, 32'h0);
        check("rst_idata_dload", idata | dload, 32'h0);
        check("rst_addr", {16'h0, ram_addr}, 32'h0);
        rst = 1'b0;

        // Fetch with ready tied high: hit in the third cycle.
        set_word(32'h40, 32'hDEADBEEF);
        fetch(32'h100, 0);
        check("fetch_hit", {31'h0, res_hit}, 32'h1);
        check("fetch_latency", res_edges, 2);
        check("fetch_idata", res_data, 32'hDEADBEEF);
        check("fetch_no_dhit", {31'h0, res_other}, 32'h0);
        check("fetch_ram_addr", {16'h0, cap_addr}, 32'h40);

        // Halfword load from the upper half of a word.
        set_word(32'h80, 32'h12345678);
        data_access(1'b1, 1'b0, 32'h202, 2'd1, 32'h0, 0);
        check("lh_data", res_data, 32'h00001234);
        check("lh_ren", {31'h0, cap_ren}, 32'h1);

        // Byte store to lane 3.
        data_access(1'b0, 1'b1, 32'h203, 2'd0, 32'h000000AB, 0);
        model_store(32'h203, 2'd0, 32'hAB);
        check("sb_hit", {31'h0, res_hit}, 32'h1);
        check("sb_be", {28'h0, cap_be}, 32'h8);
        check("sb_wdata", cap_wdata, 32'hABABABAB);
        check("sb_dload", res_data, 32'h0);
        check("sb_word", mem[32'h80], 32'hAB345678);

        // Load and store together behave as a store.
        data_access(1'b1, 1'b1, 32'h304, 2'd1, 32'h1234CAFE, 0);
        model_store(32'h304, 2'd1, 32'h1234CAFE);
        check("both_is_store", {30'h0, cap_ren, cap_wen}, 32'h1);
        check("both_be", {28'h0, cap_be}, 32'h3);
        check("both_wdata", cap_wdata, 32'hCAFECAFE);
        check("both_dload", res_data, 32'h0);

        // Five wait states: strobes held stable, hit in cycle 8.
        data_access(1'b1, 1'b0, 32'h400, 2'd2, 32'h0, 5);
        check("wait_latency", res_edges, 7);
        check("wait_strobe_cycles", strobe_cycles, 6);
        check("wait_stable", {31'h0, strobe_stable}, 32'h1);
        check("wait_data", res_data, model_load(32'h400, 2'd2));

        // Request withdrawn mid-access still completes with a hit.
        wait_left = 3;
        @(negedge clk);
        daddr = 32'h408; dwidth = 2'd2; dren = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        dren = 1'b0;
        run_until_hit(1'b1);
        check("withdraw_hit", {31'h0, res_hit}, 32'h1);
        check("withdraw_data", res_data, model_load(32'h408, 2'd2));

        // Reset during a wait-stated store: strobes drop at once, no hit, no write.
        wr_before = writes;
        wait_left = 20;
        @(negedge clk);
        daddr = 32'h500; dwidth = 2'd2; dstore = 32'h11223344; dwen = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        check("rst_mid_wen_before", {31'h0, ram_wen}, 32'h1);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_strobes", {30'h0, ram_ren, ram_wen}, 32'h0);
        @(negedge clk);
        dwen = 1'b0; wait_left = 0; rst = 1'b0;
        hit_seen = 1'b0;
        repeat (6) begin @(posedge clk); #1; if (dhit || ihit) hit_seen = 1'b1; end
        check("rst_mid_no_hit", {31'h0, hit_seen}, 32'h0);
        check("rst_mid_no_write", writes, wr_before);

        // Contention: fetch and load held continuously.
        @(negedge clk);
        iaddr = 32'h100; iren = 1'b1; daddr = 32'h200; dwidth = 2'd2; dren = 1'b1;
        n = 0; edges = 0;
        while (n < 6 && edges < 100) begin
            @(posedge clk); #1;
            edges++;
            if (ihit) begin order[n] = 32'h1; n++; end
            else if (dhit) begin order[n] = 32'h0; n++; end
        end
        @(negedge clk);
        iren = 1'b0; dren = 1'b0;
        repeat (8) @(negedge clk);
        check("cont_count", n, 6);
        consec = 0;
        for (int i = 0; i < 6; i++) begin
            if (consec < STARVE_LIMIT) begin exp_v = 32'h0; consec++; end
            else begin exp_v = 32'h1; consec = 0; end
            if (i < n) check($sformatf("cont_grant%0d_is_i", i), order[i], exp_v);
        end

        // Word store at a misaligned address.
        wr_before = writes;
        n = wen_cycles;
        data_access(1'b0, 1'b1, 32'h101, 2'd2, 32'h55667788, 0);
`ifdef MEM_MISALIGN_TRAP_EN
        check("mis_flag", {31'h0, res_mis}, 32'h1);
        check("mis_latency", res_edges, 2);
        check("mis_no_wen", wen_cycles, n);
        check("mis_no_write", writes, wr_before);
        check("mis_dload", res_data, 32'h0);
`else
        model_store(32'h101, 2'd2, 32'h55667788);
        check("mis_flag", {31'h0, res_mis}, 32'h0);
        check("mis_masked_addr", {16'h0, cap_addr}, 32'h40);
        check("mis_masked_be", {28'h0, cap_be}, 32'hF);
        check("mis_masked_word", mem[32'h40], 32'h55667788);
`endif

        // Randomized aligned traffic against the byte model.
        for (int t = 0; t < 40; t++) begin
            kind  = $urandom_range(0, 2);
            w     = 2'($urandom_range(0, 2));
            a     = 32'($urandom_range(0, MEM_WORDS*4 - 1));
            waits = $urandom_range(0, 2);
            if (kind == 0) begin
                fetch(a, waits);
                check($sformatf("rand%0d_fetch", t), res_data, model_load(a, 2'd2));
            end else if (kind == 1) begin
                a = eff_addr(a, w);
                data_access(1'b1, 1'b0, a, w, 32'h0, waits);
                check($sformatf("rand%0d_load", t), res_data, model_load(a, w));
            end else begin
                a  = eff_addr(a, w);
                sd = $urandom;
                data_access(1'b0, 1'b1, a, w, sd, waits);
                model_store(a, w, sd);
                check($sformatf("rand%0d_store_dload", t), res_data, 32'h0);
            end
            check($sformatf("rand%0d_latency", t), res_edges, 2 + waits);
        end

        bad_words = 0;
        for (int i = 0; i < MEM_WORDS; i++)
            if (mem[i] !== {model[i*4+3], model[i*4+2], model[i*4+1], model[i*4]}) bad_words++;
        check("final_mem_image", bad_words, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
